// File: rtl/ro_entropy_sampler_pkg.sv
// rtl/ro_entropy_sampler_pkg.sv - shared states and widths for the ring-oscillator entropy sampler
package ro_entropy_sampler_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    localparam int BYTE_W = 8;
    localparam int CNT_W  = 16;

endpackage

// File: rtl/ro_entropy_sampler_sync_2ff.sv
// rtl/ro_entropy_sampler_sync_2ff.sv - single-bit two-flop synchroniser with async active-low clear
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ro_entropy_sampler.sv
// rtl/ro_entropy_sampler.sv - ring-oscillator sampler: warm-up, XOR combine, von Neumann debias, byte packing
module ro_entropy_sampler
    import ro_entropy_sampler_pkg::*;
#(
    parameter int NUM_RO = 4,
    parameter int DIV    = 16,
    parameter int WARMUP = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic [NUM_RO-1:0] ro_i,
    output logic              ro_en_o,
    output logic [BYTE_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overrun_o
);

    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
    // Loading WARMUP-1 and leaving at zero gives exactly WARMUP enabled cycles.
    localparam logic [CNT_W-1:0] WU_LOAD  = CNT_W'(WARMUP - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wu_cnt, div_cnt;
    logic [NUM_RO-1:0] ro_sync;
    logic              raw;
    logic              pair_flag, a_bit;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-2:0] sr;
    logic              tick, emit, byte_done;
    logic [BYTE_W-1:0] byte_nxt;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_RO; gi++) begin : g_sync
            sync_2ff u_sync (
                .clk   (clk),
                .rst_n (rst_n),
                .d     (ro_i[gi]),
                .q     (ro_sync[gi])
            );
        end
    endgenerate

    assign raw = ^ro_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start_i) state_nxt = S_WARMUP;
            S_WARMUP: begin
                if (!start_i)          state_nxt = S_IDLE;
                else if (wu_cnt == '0) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: if (!start_i) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ro_en_o = (state == S_WARMUP) || (state == S_SAMPLE);
    end

    // No sampling in the cycle we are leaving, so a stop never lands a byte.
    assign tick      = (state == S_SAMPLE) && start_i && (div_cnt == DIV_LAST);
    assign emit      = tick && pair_flag && (a_bit != raw);
    assign byte_done = emit && (bit_cnt == 3'd7);
    assign byte_nxt  = {sr, a_bit};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wu_cnt <= '0;
        end else if (state == S_IDLE && start_i) begin
            wu_cnt <= WU_LOAD;
        end else if (state == S_WARMUP && wu_cnt != '0) begin
            wu_cnt <= wu_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state != S_SAMPLE || div_cnt == DIV_LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_flag <= 1'b0;
            a_bit     <= 1'b0;
            bit_cnt   <= '0;
            sr        <= '0;
        end else if (state_nxt == S_IDLE) begin
            pair_flag <= 1'b0;
            a_bit     <= 1'b0;
            bit_cnt   <= '0;
            sr        <= '0;
        end else if (tick) begin
            if (!pair_flag) begin
                a_bit     <= raw;
                pair_flag <= 1'b1;
            end else begin
                pair_flag <= 1'b0;
                if (emit) begin
                    sr      <= byte_nxt[BYTE_W-2:0];
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (byte_done && (!valid_o || ready_i)) begin
                data_o  <= byte_nxt;
                valid_o <= 1'b1;
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            if (state == S_IDLE && start_i) begin
                overrun_o <= 1'b0;
            end else if (byte_done && valid_o && !ready_i) begin
                overrun_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ro_entropy_sampler.sv
// tb/tb_ro_entropy_sampler.sv - self-checking bench for ro_entropy_sampler
module tb_ro_entropy_sampler;

    localparam int NUM_RO = 3;
    localparam int DIV    = 4;
    localparam int WARMUP = 6;
    localparam int NEVER  = 32'h7fff_ffff;

    typedef bit         bit_q_t[$];
    typedef logic [7:0] byte_q_t[$];
    typedef struct {
        bit         samples[32];
        int         n;
        logic [7:0] exp_byte;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_i;
    logic [NUM_RO-1:0] ro_i;
    logic              ro_en_o;
    logic [7:0]        data_o;
    logic              valid_o;
    logic              ready_i;
    logic              overrun_o;

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    byte_q_t    exp_q;
    bit_q_t     feed_q;
    int         next_feed = NEVER;
    int         t0 = 0;
    int         ready_mode = 1;
    int         consume_edge = NEVER;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = '0;
    vec_t       tbl[5];

    ro_entropy_sampler #(
        .NUM_RO (NUM_RO),
        .DIV    (DIV),
        .WARMUP (WARMUP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .ro_i      (ro_i),
        .ro_en_o   (ro_en_o),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .overrun_o (overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One negedge: drive ready, score transfers, then place the next oscillator value.
    task automatic tick();
        bit          s;
        logic [31:0] r;
        @(negedge clk);
        ready_i = (ready_mode == 1) || (ready_mode == 2 && cyc + 1 == consume_edge);
        if (valid_o && prev_valid && !prev_ready)
            check("hold_stable", data_o, prev_data);
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_byte: got %0h expected none", data_o);
            end else begin
                check("byte", data_o, exp_q.pop_front());
            end
        end
        prev_valid = valid_o;
        prev_ready = ready_i;
        prev_data  = data_o;
        r = $urandom;
        if (cyc + 1 == next_feed) begin
            s = (feed_q.size() != 0) ? feed_q.pop_front() : 1'b0;
            next_feed += DIV;
            ro_i = {s ^ r[0] ^ r[1], r[1:0]};
        end else begin
            ro_i = r[NUM_RO-1:0];
        end
    endtask

    // Called at a negedge with the DUT in IDLE; warm-up starts at the next posedge.
    task automatic start_run(input bit_q_t s);
        start_i   = 1'b1;
        feed_q    = s;
        next_feed = cyc + 1 + WARMUP + DIV - 2;
        t0        = cyc + 1 + WARMUP + DIV;
    endtask

    task automatic stop_run();
        start_i   = 1'b0;
        feed_q.delete();
        next_feed = NEVER;
        tick();
        check("ro_en_off", ro_en_o, 1'b0);
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            if (exp_q.size() == 0 && feed_q.size() == 0) break;
            tick();
        end
        if (k == budget) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes pending expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_cycles(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic bit_q_t rand_pairs(input int n);
        bit_q_t q;
        bit     a;
        for (int i = 0; i < n; i++) begin
            a = 1'($urandom);
            q.push_back(a);
            q.push_back(~a);
        end
        return q;
    endfunction

    function automatic byte_q_t vn_bytes(input bit_q_t s);
        byte_q_t    q;
        logic [7:0] acc = '0;
        int         nb = 0;
        for (int i = 0; i + 1 < s.size(); i += 2) begin
            if (s[i] != s[i+1]) begin
                acc = {acc[6:0], s[i]};
                nb++;
                if (nb == 8) begin
                    q.push_back(acc);
                    nb = 0;
                end
            end
        end
        return q;
    endfunction

    // Samples that should yield byte b, with an equal (discarded) pair before each bit set in eqm.
    function automatic vec_t mk(input logic [7:0] b, input logic [7:0] eqm);
        vec_t v;
        v.exp_byte = b;
        v.n = 0;
        for (int i = 0; i < 32; i++) v.samples[i] = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (eqm[i]) begin
                v.samples[v.n]   = i[0];
                v.samples[v.n+1] = i[0];
                v.n += 2;
            end
            v.samples[v.n]   = b[i];
            v.samples[v.n+1] = ~b[i];
            v.n += 2;
        end
        return v;
    endfunction

    initial begin
        bit_q_t  s;
        byte_q_t b;
        int      k;

        tbl[0] = mk(8'hFF, 8'h00);
        tbl[1] = mk(8'h55, 8'h7F);
        tbl[2] = mk(8'hA5, 8'h00);
        tbl[3] = mk(8'h00, 8'h81);
        tbl[4] = mk(8'h3C, 8'h55);

        rst_n   = 1'b0;
        start_i = 1'b1;
        ready_i = 1'b0;
        ro_i    = '0;
        wait_cycles(3);
        check("rst_ro_en", ro_en_o, 1'b0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_data", data_o, 8'h00);
        check("rst_overrun", overrun_o, 1'b0);

        for (int i = 0; i < 5; i++) begin
            s.delete();
            for (int j = 0; j < tbl[i].n; j++) s.push_back(tbl[i].samples[j]);
            if (i == 0) begin
                rst_n = 1'b1;
                start_run(s);
                tick();
                check("ro_en_after_reset", ro_en_o, 1'b1);
            end else begin
                stop_run();
                start_run(s);
            end
            exp_q.push_back(tbl[i].exp_byte);
            drain("table", WARMUP + DIV * (tbl[i].n + 4) + 20);
        end

        // Backpressure: first byte held, second dropped, overrun sticky until restart.
        stop_run();
        ready_mode = 0;
        s = rand_pairs(16);
        b = vn_bytes(s);
        start_run(s);
        exp_q.push_back(b[0]);
        wait_cycles(WARMUP + DIV * 34 + 10);
        check("bp_valid", valid_o, 1'b1);
        check("bp_data", data_o, b[0]);
        check("bp_overrun", overrun_o, 1'b1);
        ready_mode = 1;
        drain("bp", 20);
        tick();
        check("bp_valid_after", valid_o, 1'b0);
        check("bp_overrun_sticky", overrun_o, 1'b1);
        stop_run();
        check("bp_overrun_idle", overrun_o, 1'b1);
        s.delete();
        start_run(s);
        tick();
        check("bp_overrun_cleared", overrun_o, 1'b0);

        // Consume the held byte in the very cycle the next one completes.
        stop_run();
        ready_mode = 2;
        s = rand_pairs(16);
        b = vn_bytes(s);
        start_run(s);
        consume_edge = t0 + 31 * DIV;
        exp_q.push_back(b[0]);
        exp_q.push_back(b[1]);
        for (k = 0; k < 2000 && cyc < consume_edge; k++) tick();
        check("cc_reached", cyc >= consume_edge, 1'b1);
        check("cc_valid", valid_o, 1'b1);
        check("cc_data", data_o, b[1]);
        check("cc_overrun", overrun_o, 1'b0);
        ready_mode = 1;
        drain("cc", 20);

        // Stop after five debiased bits; the restarted byte holds only new bits.
        stop_run();
        s = rand_pairs(5);
        start_run(s);
        for (k = 0; k < 2000 && cyc < t0 + 9 * DIV + 2; k++) tick();
        stop_run();
        check("stop_valid", valid_o, 1'b0);
        s = rand_pairs(8);
        b = vn_bytes(s);
        start_run(s);
        exp_q.push_back(b[0]);
        drain("restart", WARMUP + DIV * 20 + 20);

        // Asynchronous reset mid-SAMPLE with a held byte and overrun set.
        stop_run();
        ready_mode = 0;
        s = rand_pairs(16);
        start_run(s);
        wait_cycles(WARMUP + DIV * 34 + 10);
        check("ar_valid_before", valid_o, 1'b1);
        check("ar_overrun_before", overrun_o, 1'b1);
        #2 rst_n = 1'b0;
        start_i = 1'b0;
        #1;
        check("ar_ro_en", ro_en_o, 1'b0);
        check("ar_valid", valid_o, 1'b0);
        check("ar_data", data_o, 8'h00);
        check("ar_overrun", overrun_o, 1'b0);
        feed_q.delete();
        next_feed = NEVER;
        tick();
        rst_n = 1'b1;
        wait_cycles(3);
        check("ar_idle_ro_en", ro_en_o, 1'b0);
        check("ar_idle_valid", valid_o, 1'b0);

        check("exp_q_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_entropy_sampler.md
Name: ro_entropy_sampler

Overview:
- Downstream consumer of the free-running ring oscillators in the RNG path.
- Enables NUM_RO oscillators and waits a warm-up period.
- Then synchronises their outputs, XOR-combines them into one raw bit at a programmable rate, von-Neumann-debiases the stream and packs it into bytes.
- Bytes leave on a valid/ready handshake for the downstream conditioner or bus interface.

Parameters:
- NUM_RO, 4, number of ring-oscillator inputs (1..16).
- DIV, 16, sample period in clk cycles (2..65535).
- WARMUP, 64, clk cycles between asserting ro_en_o and the first sample (1..65535).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  level. 1 = run, 0 = stop and power down the oscillators.
- ro_i  input  NUM_RO  raw oscillator outputs, asynchronous to clk.
- ro_en_o  output  1  enable to all oscillators' en inputs.
- data_o  output  8  random byte. The first debiased bit lands in bit 7, the last in bit 0.
- valid_o  output  1  data_o holds an unconsumed byte.
- ready_i  input  1  consumer accepts data_o.
- overrun_o  output  1  sticky: a completed byte was discarded because the output register was full.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; ro_en_o=0, valid_o=0, data_o=0, overrun_o=0.
  - Divider, warm-up counter, pair flag, bit counter and shift register all 0.
  - Synchroniser flops also cleared.
- Synchronisation:
  - Each ro_i bit passes through its own 2-flop synchroniser.
  - raw = XOR of all synchronised bits.
  - Latency from ro_i to raw is 2 clk.
- State machine:
  - IDLE: ro_en_o=0. start_i=1 -> WARMUP, loads the warm-up counter, clears overrun_o.
  - WARMUP: ro_en_o=1. Counter decrements each cycle; at 0 -> SAMPLE with the divider cleared. start_i=0 -> IDLE.
  - SAMPLE: ro_en_o=1. start_i=0 -> IDLE.
  - On any entry to IDLE: clear the pair flag, bit counter and shift register. valid_o/data_o are preserved until the handshake completes.
- Sample tick (SAMPLE only):
  - Divider counts 0..DIV-1; tick asserts when divider == DIV-1, so the first tick comes DIV cycles after entering SAMPLE.
  - The value of raw in the tick cycle is the sample.
- Von Neumann debiaser:
  - Even tick: store sample as a, set the pair flag.
  - Odd tick: b = sample, clear the pair flag. If a != b, emit bit a (01 -> 0, 10 -> 1). If a == b, emit nothing.
- Packing:
  - Each emitted bit shifts into the shift register from the LSB (sr <= {sr[6:0], bit}); the bit counter increments.
  - On the 8th bit the byte completes:
    - If the output register is free (valid_o=0), or is being consumed this cycle (valid_o & ready_i), load data_o and set valid_o the next cycle.
    - Otherwise drop the byte and set overrun_o.
  - Either way the bit counter returns to 0.
- Handshake:
  - Transfer occurs when valid_o & ready_i on a rising clk.
  - Completion and consumption in the same cycle leaves valid_o=1 with the new byte.
  - data_o is stable while valid_o=1 and not accepted.
  - ready_i is ignored when valid_o=0.
- Widths:
  - Divider and warm-up counters are 16 bits, with no wrap beyond their terminal values.
  - Bit counter is 3 bits plus completion detect.
- Boundary cases:
  - start_i deasserted mid-byte: the partial byte is discarded.
  - start_i toggled 1 -> 0 -> 1: warm-up runs in full again.
  - overrun_o clears only on reset or IDLE -> WARMUP.

Decomposition:
- Shared package/include:
  - State encodings IDLE=2'd0, WARMUP=2'd1, SAMPLE=2'd2.
  - BYTE_W=8.
  - Counter width constant CNT_W=16.
- One sub-module: sync_2ff (single-bit, async active-low clear), instantiated NUM_RO times in a generate loop.

Test Plan:
- Reset and start:
  - Stimulus: rst_n low with start_i=1.
  - Required: all outputs 0. After release, ro_en_o=1 on the next clk, and the first tick occurs WARMUP+DIV cycles after that.
- Debias output:
  - Stimulus: NUM_RO=1, ro_i driven so successive samples are 1,0 repeated 8 times.
  - Required: one byte, data_o=8'hFF, valid_o=1.
- Debias discards and bit order:
  - Stimulus: samples 0,0 / 1,1 interleaved with pairs 0,1 / 1,0 alternating, starting 0,1.
  - Required: equal pairs emit nothing; data_o=8'h55 after 8 unequal pairs.
- Backpressure:
  - Stimulus: ready_i=0 for two full bytes.
  - Required: first byte held unchanged on data_o; second byte discarded; overrun_o=1. Restarting start_i clears overrun_o.
- Simultaneous consume and complete:
  - Stimulus: ready_i=1 in the cycle the next byte completes.
  - Required: valid_o stays 1 and data_o updates to the new byte with no gap.
- Stop mid-operation:
  - Stimulus: start_i=0 after 5 bits, then start_i=1.
  - Required: ro_en_o=0 next clk; the next byte contains only post-restart bits. An async rst_n pulse mid-SAMPLE clears everything immediately.
